// File: rtl/coeff_recomposer_if.sv
// Stream bus for coeff_recomposer: input beat (sec_lvl, dia, dib)
// and output beat (doc, err_o), each with its own valid/ready pair.
interface coeff_recomposer_if;
    logic [2:0]  sec_lvl;
    logic        valid_i;
    logic        ready_i;
    logic [23:0] dia;
    logic [23:0] dib;
    logic [23:0] doc;
    logic        valid_o;
    logic        ready_o;
    logic        err_o;

    modport master (
        output sec_lvl, valid_i, dia, dib, ready_o,
        input  ready_i, doc, valid_o, err_o
    );

    modport slave (
        input  sec_lvl, valid_i, dia, dib, ready_o,
        output ready_i, doc, valid_o, err_o
    );
endinterface

// File: rtl/coeff_recomposer.sv
// Dilithium recomposer: r = (r1*2*gamma2 + r0) mod q, two-stage pipeline.
// Optional range check compiled in with COEFF_RECOMP_RANGE_CHECK_EN.
module coeff_recomposer (
    input  logic              clk,
    input  logic              rst,
    coeff_recomposer_if.slave bus
);
    localparam logic [22:0] Q       = 23'd8380417;
    localparam logic [17:0] ALPHA2  = 18'd190464;
    localparam logic [18:0] ALPHA35 = 19'd523776;
    localparam logic [23:0] Q24     = {1'b0, Q};

    logic               adv1, adv2, acc, lvl2;
    logic               v1_q, v2_q;
    logic [23:0]        p2, p35, p_d, p1_q;
    logic signed [24:0] r0_d, r01_q;
    logic signed [24:0] s;
    logic [23:0]        s_add, s_sub;
    logic [23:0]        doc_d, doc_q;

    assign adv2        = !v2_q | bus.ready_o;
    assign adv1        = !v1_q | adv2;
    assign bus.ready_i = adv1 & rst;
    assign acc         = bus.valid_i & bus.ready_i;
    assign lvl2        = (bus.sec_lvl == 3'd2);
    assign r0_d        = {bus.dib[23], bus.dib};

    // Constant multiply unrolled into one shifted add per set bit of alpha
    always_comb begin
        p2  = '0;
        p35 = '0;
        for (int k = 0; k < 18; k++)
            if (ALPHA2[k]) p2 = p2 + (bus.dia << k);
        for (int k = 0; k < 19; k++)
            if (ALPHA35[k]) p35 = p35 + (bus.dia << k);
    end

    assign p_d = lvl2 ? p2 : p35;

    assign s     = $signed({1'b0, p1_q}) + r01_q;
    assign s_add = s[23:0] + Q24;
    assign s_sub = s[23:0] - Q24;

`ifdef COEFF_RECOMP_RANGE_CHECK_EN
    localparam logic signed [24:0] G2_2  = 25'sd95232;
    localparam logic signed [24:0] G2_35 = 25'sd261888;

    logic               err_d, err1_q, err2_q;
    logic signed [24:0] g2;
    logic [23:0]        r1_max;

    assign g2     = lvl2 ? G2_2 : G2_35;
    assign r1_max = lvl2 ? 24'd43 : 24'd15;
    assign err_d  = (bus.dia > r1_max) | (r0_d > g2) | (r0_d < -g2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err1_q <= 1'b0;
            err2_q <= 1'b0;
        end else begin
            if (acc) err1_q <= err_d;
            if (adv2 && v1_q) err2_q <= err1_q;
        end
    end

    assign bus.err_o = v2_q & err2_q;
`else
    assign bus.err_o = 1'b0;
`endif

    // s is within one modulus of [0, q) for legal inputs
    always_comb begin
        doc_d = s[23:0];
        if (s[24])
            doc_d = s_add;
        else if (s >= $signed({2'b00, Q}))
            doc_d = s_sub;
`ifdef COEFF_RECOMP_RANGE_CHECK_EN
        if (err1_q) doc_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            p1_q  <= '0;
            r01_q <= '0;
            doc_q <= '0;
        end else begin
            if (adv1) begin
                v1_q <= acc;
                if (acc) begin
                    p1_q  <= p_d;
                    r01_q <= r0_d;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) doc_q <= doc_d;
            end
        end
    end

    assign bus.valid_o = v2_q;
    assign bus.doc     = doc_q;
endmodule

// File: tb/tb_coeff_recomposer.sv
// Directed bench for coeff_recomposer: values, latency, stalls, reset.
// Range-check scenarios run when COEFF_RECOMP_RANGE_CHECK_EN is defined.
module tb_coeff_recomposer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    coeff_recomposer_if bus ();

    coeff_recomposer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic run_beat(input logic [2:0] l, input logic [23:0] a,
                            input logic [23:0] b, output logic [23:0] d,
                            output logic e, output int lat);
        bus.sec_lvl = l;
        bus.dia     = a;
        bus.dib     = b;
        bus.ready_o = 1'b1;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        lat = 1;
        while (!bus.valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.doc;
        e = bus.err_o;
    endtask

    task automatic test_reset();
        bus.valid_i = 1'b0;
        bus.ready_o = 1'b0;
        bus.sec_lvl = 3'd2;
        bus.dia     = '0;
        bus.dib     = '0;
        #12;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b exp 0", bus.valid_o);
        end
        checks++;
        if (bus.ready_i !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got %b exp 0", bus.ready_i);
        end
        checks++;
        if (bus.doc !== 24'd0) begin
            errors++;
            $display("FAIL rst_doc got %0d exp 0", bus.doc);
        end
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_err got %b exp 0", bus.err_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ready_i !== 1'b1) begin
            errors++;
            $display("FAIL rel_ready got %b exp 1", bus.ready_i);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        logic [23:0] d;
        logic        e;
        int          lat;
        run_beat(3'd2, 24'd0, 24'd0, d, e, lat);
        checks++;
        if (d !== 24'd0) begin
            errors++;
            $display("FAIL zero_doc got %0d exp 0", d);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL zero_latency got %0d exp 2", lat);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL zero_err got %b exp 0", e);
        end
    endtask

    task automatic test_values();
        logic [2:0]  lv [5] = '{3'd2, 3'd3, 3'd2, 3'd0, 3'd5};
        logic [23:0] ra [5] = '{24'd0, 24'd15, 24'd43, 24'd2, 24'd1};
        logic [23:0] rb [5] = '{24'hFFFFFF, 24'd1000, 24'd95232,
                                24'd0, 24'hFC0100};
        logic [23:0] ex [5] = '{24'd8380416, 24'd7857640, 24'd8285184,
                                24'd1047552, 24'd261888};
        logic [23:0] d;
        logic        e;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_beat(lv[i], ra[i], rb[i], d, e, lat);
            checks++;
            if (d !== ex[i] || lat != 2) begin
                errors++;
                $display("FAIL value_%0d got %0d lat %0d exp %0d lat 2",
                         i, d, lat, ex[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] exp_q [5] = '{24'd190464, 24'd380928, 24'd571392,
                                   24'd761856, 24'd952320};
        logic        rdy_exp [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b1};
        int   sent = 0;
        int   got  = 0;
        logic acc, emit;
        bus.ready_o = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            bus.ready_o = !(c >= 2 && c <= 4);
            bus.valid_i = (sent < 5);
            bus.dia     = 24'(sent + 1);
            bus.dib     = '0;
            bus.sec_lvl = 3'd2;
            #1;
            if (c < 8) begin
                checks++;
                if (bus.ready_i !== rdy_exp[c]) begin
                    errors++;
                    $display("FAIL bp_ready_c%0d got %b exp %b",
                             c, bus.ready_i, rdy_exp[c]);
                end
            end
            if (c >= 2) begin
                checks++;
                if (bus.valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_gap_c%0d got %b exp 1", c, bus.valid_o);
                end
            end
            if (bus.valid_o) begin
                checks++;
                if (bus.doc !== exp_q[got]) begin
                    errors++;
                    $display("FAIL bp_doc_%0d got %0d exp %0d",
                             got, bus.doc, exp_q[got]);
                end
            end
            acc  = bus.valid_i & bus.ready_i;
            emit = bus.valid_o & bus.ready_o;
            @(posedge clk); #1;
            if (acc) sent++;
            if (emit) got++;
        end
        bus.valid_i = 1'b0;
        bus.ready_o = 1'b1;
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL bp_count got %0d exp 5", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] d;
        logic        e;
        int          lat;
        int          extra = 0;
        bus.ready_o = 1'b0;
        bus.sec_lvl = 3'd2;
        bus.dib     = '0;
        for (int i = 0; i < 2; i++) begin
            bus.dia     = 24'(7 + i);
            bus.valid_i = 1'b1;
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_inflight got %b exp 1", bus.valid_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_i !== 1'b0) begin
            errors++;
            $display("FAIL mid_flush valid %b ready %b exp 0 0",
                     bus.valid_o, bus.ready_i);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        run_beat(3'd2, 24'd2, 24'hFFFFFB, d, e, lat);
        checks++;
        if (d !== 24'd380923 || lat != 2) begin
            errors++;
            $display("FAIL mid_first got %0d lat %0d exp 380923 lat 2", d, lat);
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.valid_o) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL mid_extra got %0d exp 0", extra);
        end
    endtask

`ifdef COEFF_RECOMP_RANGE_CHECK_EN
    task automatic test_range();
        logic [23:0] d;
        logic        e;
        int          lat;
        run_beat(3'd2, 24'd44, 24'd0, d, e, lat);
        checks++;
        if (e !== 1'b1 || d !== 24'd0) begin
            errors++;
            $display("FAIL rng_r1 err %b doc %0d exp 1 0", e, d);
        end
        run_beat(3'd3, 24'd15, 24'd261889, d, e, lat);
        checks++;
        if (e !== 1'b1 || d !== 24'd0) begin
            errors++;
            $display("FAIL rng_r0 err %b doc %0d exp 1 0", e, d);
        end
        run_beat(3'd2, 24'd43, 24'd95232, d, e, lat);
        checks++;
        if (e !== 1'b0 || d !== 24'd8285184) begin
            errors++;
            $display("FAIL rng_ok err %b doc %0d exp 0 8285184", e, d);
        end
    endtask
`else
    task automatic test_wrap_high();
        logic [23:0] d;
        logic        e;
        int          lat;
        run_beat(3'd2, 24'd44, 24'd1, d, e, lat);
        checks++;
        if (d !== 24'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL wrap_q got %0d err %b exp 0 0", d, e);
        end
        run_beat(3'd2, 24'd44, 24'd5, d, e, lat);
        checks++;
        if (d !== 24'd4) begin
            errors++;
            $display("FAIL wrap_q4 got %0d exp 4", d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_backpressure();
        test_reset_mid();
`ifdef COEFF_RECOMP_RANGE_CHECK_EN
        test_range();
`else
        test_wrap_high();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coeff_recomposer.md
# coeff_recomposer

Inverse of `coeff_decomposer` in the Dilithium datapath. It takes a high part r1 and a centered low part r0 of one coefficient and rebuilds r = (r1·2γ2 + r0) mod q, with the result in [0, q). It sits downstream of hint/high-bits processing, where verify and sign paths need full coefficients back. It uses the same valid/ready stream handshake and `sec_lvl` convention as the decomposer.

## Interface
- `Q`, 23'd8380417, field modulus
- `ALPHA2`, 18'd190464, 2γ2 for sec_lvl 2 (γ2 = 95232, r1 max 43)
- `ALPHA35`, 19'd523776, 2γ2 for sec_lvl 3/5 (γ2 = 261888, r1 max 15)

Ports:
- `clk` input 1: clock, rising edge
- `rst` input 1: asynchronous, active-low reset
- `sec_lvl` input 3: 3'd2 selects level-2 constants; any other value selects level-3/5 constants; sampled per beat
- `valid_i` input 1: input beat valid
- `ready_i` output 1: block can accept an input beat
- `dia` input 24: r1, unsigned, in the low bits
- `dib` input 24: r0, two's complement
- `doc` output 24: recomposed coefficient, zero-extended
- `valid_o` output 1: output beat valid
- `ready_o` input 1: downstream ready
- `err_o` output 1: range-error flag for the output beat

## Operation
- An input beat transfers on `valid_i & ready_i`. An output beat transfers on `valid_o & ready_o`.
- The pipeline has two register stages, S1 and S2. S2 drives the outputs.
- **S1 captures:**
  - p = r1·α, built as a shift-add constant multiply and sized to 24 bits.
  - r0 sign-extended to 25 bits.
  - The level select.
  - The range-check result.
- **S2 computes and captures:**
  - s = p + r0, signed, 25 bits.
  - If s < 0, then doc = s + Q.
  - Else if s ≥ Q, then doc = s − Q.
  - Else doc = s.
- For valid inputs, s lies in [−γ2, Q−1+γ2], so a single correction step is always sufficient.
- **Stall rule:**
  - adv2 = !v2 | ready_o.
  - adv1 = !v1 | adv2.
  - ready_i = adv1 & rst.
- All valid and data registers hold while their stage does not advance. No beat is lost or duplicated, and beats leave in order.
- There is no FSM. The pipeline state is fully described by the pair (v1, v2).

## Timing
- **Reset** (`rst` low, asynchronous):
  - v1, v2, `valid_o`, `doc`, and `err_o` clear to 0.
  - `ready_i` is 0 while `rst` is low and rises combinationally on release.
- **Latency:** 2 cycles. A beat accepted at edge n appears with `valid_o`=1 after edge n+2 when there is no stall.
- **Throughput:** 1 beat per cycle with `ready_o` held high.
- **Backpressure:**
  - With `ready_o` low, `ready_i` stays high until both stages hold data, then drops on the next cycle.
  - `ready_i` returns the same cycle `ready_o` rises, as a combinational path.
- **Simultaneous accept and emit:** with both stages full and `ready_o` high, S2 emits, S1 moves to S2, and a new beat enters S1 in the same edge.
- **Reset mid-stream:** every in-flight beat is discarded. The first post-reset output is the first beat accepted after release.
- `valid_o` and `doc` are stable while `valid_o & !ready_o`.

## Configuration
- **`COEFF_RECOMP_RANGE_CHECK_EN` defined:**
  - S1 flags an error when r1 exceeds the level max (43 or 15), or when r0 lies outside [−γ2, γ2].
  - An erroring beat still flows through the pipeline and emits with `err_o`=1 and `doc`=0.
  - `err_o` is qualified by `valid_o`.
- **Macro undefined:**
  - No check logic is compiled in, and `err_o` is tied to 0.
  - Out-of-range inputs produce the arithmetic result of the formula with the single correction step. That result is unspecified but must not hang the pipeline.

## Test plan
- **Zero input:** reset release; lvl 2, `dia`=0, `dib`=0 → `doc`=0 and `valid_o`=1 exactly 2 cycles after accept.
- **Negative wrap:** lvl 2, `dia`=0, `dib`=24'hFFFFFF (r0 = −1) → `doc`=8380416.
- **Level 3 and 2 values:**
  - lvl 3, `dia`=15, `dib`=1000 → `doc`=7857640.
  - lvl 2, `dia`=43, `dib`=95232 → `doc`=8285184.
- **Backpressure:** stream 5 beats (r1 = 1..5, r0 = 0, lvl 2) with `ready_o` low for cycles 2–4.
  - `ready_i` drops once both stages are full.
  - Outputs are 190464, 380928, 571392, 761856, 952320, in order, with no gaps when `ready_o` stays high.
- **Reset mid-stream:** assert `rst` low with 2 beats in flight.
  - `valid_o` goes to 0 immediately.
  - After release, one beat (r1 = 2, r0 = −5, lvl 2) → `doc`=380923 and nothing else is emitted.
- **Range check (macro defined):**
  - lvl 2, `dia`=44 → `err_o`=1, `doc`=0.
  - lvl 3, `dia`=15, `dib`=261889 → `err_o`=1.
  - A valid beat that follows → `err_o`=0 with the correct `doc`.
